led_pattern_engine: RTL and testbench

Parametrised LED effect generator for the vending front panel: drives LED_NUM indicator LEDs with static, running, ping-pong, counted-flash and PWM breathing effects selected by a mode code. It replaces the fixed 4-LED driver and sits between the control FSM and the board LED pins. Adds a completion pulse for the counted flash, so the control FSM can sequence effects.

---
 rtl/led_pattern_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_led_pattern_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// LED effect generator for the vending front panel: static, running, ping-pong,
// counted-flash and PWM breathing effects over LED_NUM indicators.

package led_pattern_pkg;
  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_ON      = 3'd1,
    M_SINGLE  = 3'd2,
    M_RUN     = 3'd3,
    M_BOUNCE  = 3'd4,
    M_FLASH   = 3'd5,
    M_BREATHE = 3'd6,
    M_RSVD    = 3'd7
  } mode_e;

  typedef enum logic {
    FL_RUN  = 1'b0,
    FL_DONE = 1'b1
  } flash_st_e;

  // Per-LED decode request; pos is carried at the widest LED index (16 LEDs).
  typedef struct packed {
    mode_e      mode;
    logic       blank;
    logic [3:0] sel;
    logic [3:0] pos;
    logic       flash_lit;
    logic       pwm_lit;
  } lane_req_t;
endpackage

// One LED: decides whether this index is lit for the current effect.
module led_pattern_lane
  import led_pattern_pkg::*;
#(
  parameter int IDX = 0
) (
  input  lane_req_t req_i,
  output logic      lit_o
);
  always_comb begin
    lit_o = 1'b0;
    if (!req_i.blank) begin
      case (req_i.mode)
        M_ON:              lit_o = 1'b1;
        M_SINGLE:          lit_o = (req_i.sel == 4'(IDX));
        M_RUN, M_BOUNCE:   lit_o = (req_i.pos == 4'(IDX));
        M_FLASH:           lit_o = req_i.flash_lit;
        M_BREATHE:         lit_o = req_i.pwm_lit;
        default:           lit_o = 1'b0;
      endcase
    end
  end
endmodule

module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int LED_NUM  = 4,
  parameter int TICK_DIV = 4_000_000,
  parameter int PWM_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         mode,
  input  logic [3:0]         sel,
  input  logic               dir,
  input  logic [3:0]         flash_cnt,
  output logic [LED_NUM-1:0] led,
  output logic               done
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(LED_NUM);
  localparam logic [TW-1:0]       TMAX = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0]       PMAX = PW'(LED_NUM - 1);
  localparam logic [PWM_BITS-1:0] DMAX = '1;

  mode_e               mode_in;
  mode_e               mode_q, mode_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                up_q, up_d;
  logic                phase_q, phase_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic [3:0]          flim_q, flim_d;
  flash_st_e           fst_q, fst_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [LED_NUM-1:0]  led_q, led_d;
  logic                done_q, done_d;

  logic       mode_chg;
  logic       animated;
  logic       tick;
  logic [3:0] fcnt_inc;
  lane_req_t  req;

  assign mode_in  = mode_e'(mode);
  assign mode_chg = (mode_in != mode_q);
  assign fcnt_inc = fcnt_q + 4'd1;

  always_comb begin
    case (mode_in)
      M_RUN, M_BOUNCE, M_FLASH, M_BREATHE: animated = 1'b1;
      default:                             animated = 1'b0;
    endcase
  end

  assign tick = animated && !mode_chg && (tcnt_q == TMAX);

  // Static modes decode straight from the inputs; animated modes from state,
  // blanked during the reload cycle so the first pattern follows the reload.
  always_comb begin
    req           = '0;
    req.mode      = mode_in;
    req.blank     = mode_chg && animated;
    req.sel       = sel;
    req.pos       = 4'(pos_q);
    req.flash_lit = phase_q && (fst_q == FL_RUN);
    req.pwm_lit   = (pwm_q < duty_q);
  end

  for (genvar i = 0; i < LED_NUM; i++) begin : g_lane
    led_pattern_lane #(.IDX(i)) u_lane (
      .req_i (req),
      .lit_o (led_d[i])
    );
  end

  always_comb begin
    mode_d  = mode_in;
    tcnt_d  = tcnt_q;
    pos_d   = pos_q;
    up_d    = up_q;
    phase_d = phase_q;
    fcnt_d  = fcnt_q;
    flim_d  = flim_q;
    fst_d   = fst_q;
    duty_d  = duty_q;
    pwm_d   = pwm_q + 1'b1;
    done_d  = 1'b0;

    if (mode_chg) begin
      tcnt_d  = '0;
      pos_d   = '0;
      up_d    = 1'b1;
      phase_d = 1'b1;
      fcnt_d  = '0;
      flim_d  = flash_cnt;
      fst_d   = FL_RUN;
      duty_d  = '0;
      pwm_d   = '0;
    end else begin
      if (!animated)  tcnt_d = '0;
      else if (tick)  tcnt_d = '0;
      else            tcnt_d = tcnt_q + 1'b1;

      if (tick) begin
        case (mode_in)
          M_RUN: begin
            if (!dir) pos_d = (pos_q == PMAX) ? '0 : pos_q + 1'b1;
            else      pos_d = (pos_q == '0) ? PMAX : pos_q - 1'b1;
          end
          M_BOUNCE: begin
            if (up_q) begin
              if (pos_q == PMAX) begin
                up_d  = 1'b0;
                pos_d = pos_q - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                up_d  = 1'b1;
                pos_d = pos_q + 1'b1;
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end
          end
          M_FLASH: begin
            if (fst_q == FL_RUN) begin
              phase_d = ~phase_q;
              // A cycle completes on the tick that ends an off phase.
              if (!phase_q && (flim_q != 4'd0)) begin
                fcnt_d = fcnt_inc;
                if (fcnt_inc == flim_q) begin
                  fst_d   = FL_DONE;
                  phase_d = 1'b0;
                  done_d  = 1'b1;
                end
              end
            end
          end
          M_BREATHE: begin
            if (up_q) begin
              if (duty_q == DMAX) begin
                up_d   = 1'b0;
                duty_d = duty_q - 1'b1;
              end else begin
                duty_d = duty_q + 1'b1;
              end
            end else begin
              if (duty_q == '0) begin
                up_d   = 1'b1;
                duty_d = duty_q + 1'b1;
              end else begin
                duty_d = duty_q - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= M_OFF;
      tcnt_q  <= '0;
      pos_q   <= '0;
      up_q    <= 1'b1;
      phase_q <= 1'b0;
      fcnt_q  <= '0;
      flim_q  <= '0;
      fst_q   <= FL_RUN;
      duty_q  <= '0;
      pwm_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      tcnt_q  <= tcnt_d;
      pos_q   <= pos_d;
      up_q    <= up_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      flim_q  <= flim_d;
      fst_q   <= fst_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign done = done_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: static decode, RUN, BOUNCE, FLASH,
// async reset, and BREATHE duty on a second instance.

module tb_led_pattern_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] mode, mode_b;
  logic [3:0] sel, flash_cnt;
  logic       dir;
  logic [3:0] led;
  logic       done;
  logic [1:0] led_b;
  logic       done_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_pattern_engine #(.LED_NUM(4), .TICK_DIV(4), .PWM_BITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .dir(dir),
    .flash_cnt(flash_cnt), .led(led), .done(done)
  );

  // Tick period equals the PWM period so each duty value spans one full PWM cycle.
  led_pattern_engine #(.LED_NUM(2), .TICK_DIV(16), .PWM_BITS(4)) u_br (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel), .dir(dir),
    .flash_cnt(flash_cnt), .led(led_b), .done(done_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] el, input logic ed);
    n_cmp++;
    assert (led === el) else begin
      n_err++;
      $error("FAIL %s: led=%b expected=%b", tag, led, el);
    end
    n_cmp++;
    assert (done === ed) else begin
      n_err++;
      $error("FAIL %s: done=%b expected=%b", tag, done, ed);
    end
  endtask

  task automatic hold(input string tag, input logic [3:0] el, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, el, 1'b0);
      step(1);
    end
  endtask

  initial begin
    int ones;
    int exp_ones;

    rst_n = 1'b0; mode = 3'd0; mode_b = 3'd0; sel = 4'd0; dir = 1'b0; flash_cnt = 4'd0;
    step(2);
    chk("reset", 4'b0000, 1'b0);
    n_cmp++;
    assert (led_b === 2'b00 && done_b === 1'b0) else begin
      n_err++;
      $error("FAIL reset_b: led=%b done=%b expected=00/0", led_b, done_b);
    end
    rst_n = 1'b1;
    step(1);

    // Static decode: one clk from input to led
    mode = 3'd1;              step(1); chk("on",       4'b1111, 1'b0);
    mode = 3'd2; sel = 4'd2;  step(1); chk("single2",  4'b0100, 1'b0);
    sel = 4'd7;               step(1); chk("single7",  4'b0000, 1'b0);
    sel = 4'd3;               step(1); chk("single3",  4'b1000, 1'b0);
    mode = 3'd7;              step(1); chk("mode7",    4'b0000, 1'b0);
    mode = 3'd2; sel = 4'd0;  step(1); chk("single0",  4'b0001, 1'b0);
    mode = 3'd0;              step(1); chk("off",      4'b0000, 1'b0);

    // RUN, dir=0 then reversed mid-run
    sel = 4'd7; dir = 1'b0; mode = 3'd3;
    step(2);
    hold("run_p0", 4'b0001, 4);
    hold("run_p1", 4'b0010, 4);
    hold("run_p2", 4'b0100, 4);
    hold("run_p3", 4'b1000, 4);
    dir = 1'b1;
    hold("run_p0b", 4'b0001, 4);
    hold("run_rev3", 4'b1000, 4);
    hold("run_rev2", 4'b0100, 4);

    // Enter BOUNCE in the same cycle RUN ticks
    step(2);
    mode = 3'd4;
    step(2);
    hold("bnc0", 4'b0001, 4);
    hold("bnc1", 4'b0010, 4);
    hold("bnc2", 4'b0100, 4);
    hold("bnc3", 4'b1000, 4);
    hold("bnc4", 4'b0100, 4);
    hold("bnc5", 4'b0010, 4);
    hold("bnc6", 4'b0001, 4);
    hold("bnc7", 4'b0010, 4);

    // Counted FLASH; flash_cnt change mid-flash must be ignored
    mode = 3'd5; flash_cnt = 4'd3;
    step(2);
    hold("fl_on1", 4'b1111, 4);
    flash_cnt = 4'd1;
    hold("fl_off1", 4'b0000, 4);
    hold("fl_on2", 4'b1111, 4);
    hold("fl_off2", 4'b0000, 4);
    hold("fl_on3", 4'b1111, 4);
    hold("fl_off3", 4'b0000, 3);
    chk("fl_done", 4'b0000, 1'b1);
    step(1);
    hold("fl_dark", 4'b0000, 50);

    // Re-entry from another mode restarts; flash_cnt=0 never completes
    flash_cnt = 4'd0; mode = 3'd0;
    step(1);
    mode = 3'd5;
    step(2);
    for (int k = 0; k < 10; k++) begin
      hold("flf_on", 4'b1111, 4);
      hold("flf_off", 4'b0000, 4);
    end

    // Async reset mid-FLASH (lit phase)
    chk("flf_lit", 4'b1111, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("rst_flash", 4'b0000, 1'b0);
    step(2);
    rst_n = 1'b1;
    chk("rst_rel", 4'b0000, 1'b0);
    step(1);
    chk("rel_reload", 4'b0000, 1'b0);
    step(1);
    chk("rel_lit", 4'b1111, 1'b0);

    // Async reset mid-RUN
    mode = 3'd3; dir = 1'b0;
    step(2);
    chk("run2_p0", 4'b0001, 1'b0);
    step(4);
    chk("run2_p1", 4'b0010, 1'b0);
    #3 rst_n = 1'b0;
    #1 chk("rst_run", 4'b0000, 1'b0);
    step(1);
    rst_n = 1'b1; mode = 3'd0;
    step(1);
    chk("rst_run_rel", 4'b0000, 1'b0);

    // BREATHE: lit count per 16-clk PWM period equals duty, 0..15..0
    mode_b = 3'd6;
    step(2);
    for (int k = 0; k <= 30; k++) begin
      ones = 0;
      for (int c = 0; c < 16; c++) begin
        ones += int'(led_b[0]);
        step(1);
      end
      exp_ones = (k <= 15) ? k : 30 - k;
      n_cmp++;
      assert (ones == exp_ones) else begin
        n_err++;
        $error("FAIL breathe_blk%0d: lit=%0d expected=%0d", k, ones, exp_ones);
      end
    end
    n_cmp++;
    assert (done_b === 1'b0) else begin
      n_err++;
      $error("FAIL breathe_done: done=%b expected=0", done_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
